// File: rtl/multiplexer_4to1.sv
// 4-to-1 lane selector with a combinational output, a one-hot select decode,
// and a one-cycle registered copy of the selected lane qualified by out_valid.
module multiplexer_4to1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*WIDTH-1:0]   i,
    input  logic [1:0]           s,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     y,
    output logic [3:0]           sel_oh,
    output logic [WIDTH-1:0]     y_q,
    output logic                 out_valid
);

    logic [WIDTH-1:0] lane_sel;

    // Select the addressed lane; only that lane's bits reach the output.
    always_comb begin
        lane_sel = '0;
        case (s)
            2'd0:    lane_sel = i[0*WIDTH +: WIDTH];
            2'd1:    lane_sel = i[1*WIDTH +: WIDTH];
            2'd2:    lane_sel = i[2*WIDTH +: WIDTH];
            default: lane_sel = i[3*WIDTH +: WIDTH];
        endcase
    end

    // One-hot decode of the select, always exactly one bit set.
    always_comb begin
        sel_oh = 4'b0001 << s;
    end

    assign y = lane_sel;

    // Capture the selected lane when qualified; out_valid marks a fresh sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q <= lane_sel;
            end
        end
    end

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Randomized scoreboard bench for multiplexer_4to1: captures are predicted
// when issued and checked by an independent monitor when out_valid appears.
module tb_multiplexer_4to1;

    localparam int unsigned WIDTH = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [4*WIDTH-1:0]   i = '0;
    logic [1:0]           s = '0;
    logic                 in_valid = 1'b0;
    logic [WIDTH-1:0]     y;
    logic [3:0]           sel_oh;
    logic [WIDTH-1:0]     y_q;
    logic                 out_valid;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] held = '0;
    logic             exp_valid = 1'b0;

    multiplexer_4to1 #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i(i),
        .s(s),
        .in_valid(in_valid),
        .y(y),
        .sel_oh(sel_oh),
        .y_q(y_q),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference: lane k is the k-th WIDTH-bit slice counted from the LSB.
    function automatic logic [WIDTH-1:0] lane_of(input logic [4*WIDTH-1:0] v, input logic [1:0] sel);
        int unsigned sh;
        sh = int'(sel) * WIDTH;
        return WIDTH'(v >> sh);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_comb();
        int unsigned oh;
        oh = 32'd1 << int'(s);
        check("y", 32'(y), 32'(lane_of(i, s)));
        check("sel_oh", 32'(sel_oh), oh);
    endtask

    task automatic drive(input logic v, input logic [4*WIDTH-1:0] iv, input logic [1:0] sv);
        in_valid = v;
        i        = iv;
        s        = sv;
        #1;
        check_comb();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse between edges; registered outputs must clear with no clock.
    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_y_q", 32'(y_q), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Issue side: predict each capture at the edge that performs it.
    always @(posedge clk) begin
        if (rst_n) begin
            exp_valid = in_valid;
            if (in_valid) sb.push_back(lane_of(i, s));
        end
    end

    // Reset discards anything in flight.
    always @(negedge rst_n) begin
        sb.delete();
        held      = '0;
        exp_valid = 1'b0;
    end

    // Monitor: pop a prediction whenever the DUT presents a sample, else expect hold.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=out_valid_high expected=no_sample t=%0t", $time);
            end else begin
                e    = sb.pop_front();
                held = e;
                check("y_q", 32'(y_q), 32'(e));
            end
        end else begin
            check("y_q_hold", 32'(y_q), 32'(held));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("reset_y_q", 32'(y_q), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        // Combinational sweeps while in reset; reset must not disturb y/sel_oh.
        for (int k = 0; k < 4; k++) drive(1'b0, 4'b0000, 2'(k));
        for (int k = 0; k < 4; k++) drive(1'b0, 4'b1010, 2'(k));
        for (int k = 0; k < 4; k++) drive(1'b0, 4'b0101, 2'(k));

        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back captures, then drop in_valid.
        next_cycle(); drive(1'b1, 4'b1001, 2'd3);
        next_cycle(); drive(1'b1, 4'b1001, 2'd0);
        next_cycle(); drive(1'b1, 4'b1001, 2'd1);
        next_cycle(); drive(1'b0, 4'b1001, 2'd1);
        next_cycle();

        // Reset with in_valid high discards the pending sample.
        drive(1'b1, 4'b1111, 2'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_y_q", 32'(y_q), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_comb();
        next_cycle();
        check("rst_hold_y_q", 32'(y_q), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 2'd2);
        next_cycle();
        check("post_rst_y_q", 32'(y_q), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd1);

        // Idle with toggling inputs: y tracks, y_q holds.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, (4*WIDTH)'($urandom), 2'($urandom));
            next_cycle();
        end

        // Random stream with occasional mid-stream resets.
        for (int k = 0; k < 80; k++) begin
            drive(1'($urandom), (4*WIDTH)'($urandom), 2'($urandom));
            if ($urandom_range(0, 11) == 0) reset_pulse();
            else next_cycle();
        end

        drive(1'b0, '0, 2'd0);
        next_cycle();
        next_cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
